mul_seq_ctrl: RTL and testbench
===============================

// Module: mul_seq_ctrl
// PURPOSE
//  Iterative shift-add multiplier for the RISC-V M unit: MUL/MULH/MULHSU/MULHU on XLEN operands.
//  Sequences one shared CLA adder for operand abs, XLEN accumulate steps and final product negation.
//  valid/ready on both sides; sits between the execute-stage issue and writeback.
// PARAMETERS
//  XLEN  64  operand/result width; the cla adder is instantiated at width=XLEN (64 only)
// PORTS
//  clk         in   1     clock; all state updates on rising edge
//  rst         in   1     reset, asynchronous, active-high
//  in_valid    in   1     request valid
//  in_ready    out  1     high only in IDLE
//  in_op       in   2     00 MUL(lo), 01 MULH(s*s), 10 MULHSU(s*u), 11 MULHU(u*u)
//  in_a        in   XLEN  multiplicand rs1
//  in_b        in   XLEN  multiplier rs2
//  kill        in   1     synchronous abort (pipeline flush)
//  out_valid   out  1     result valid, held until out_ready
//  out_ready   in   1     consumer accepts
//  out_result  out  XLEN  lo half for MUL, hi half otherwise
// BEHAVIOUR
//  - rst: state=IDLE; out_valid=0, out_result=0, in_ready=1, all regs 0 -- immediately, any state.
//  - States: IDLE -> ABS_A -> ABS_B -> MUL(xXLEN, 7-bit count) -> NEG_LO -> NEG_HI -> DONE -> IDLE.
//  - Accept edge (in_valid&in_ready) = edge 0: latch op, a, b; neg_a=a[XLEN-1]&op in{01,10},
//    neg_b=b[XLEN-1]&op==01, neg_p=neg_a^neg_b. MUL op: no abs, no neg.
//  - ABS_A: if neg_a mcand<=~a+1 via adder (op2=1) else hold. ABS_B: same for b into lo.
//    -2^(XLEN-1) yields magnitude 2^(XLEN-1) as unsigned: correct, no special case.
//  - MUL step: {hi,lo} 2*XLEN reg, hi=0 at start. lo[0]=1: {cout,sum}=hi+mcand;
//    {hi,lo}<={cout,sum,lo[XLEN-1:1]}. lo[0]=0: {hi,lo}<={1'b0,hi,lo[XLEN-1:1]}.
//  - NEG_LO: if neg_p lo<=~lo+1, c<=cout. NEG_HI: if neg_p hi<=~hi+{0,c}. else both hold.
//  - Fixed latency regardless of op/data: DONE (out_valid=1) reached at edge XLEN+4 (68 @64).
//  - DONE: out_result registered, stable while out_ready=0; out_valid&out_ready -> IDLE next edge,
//    in_ready=1 cycle after; no same-cycle accept of next request (1 bubble).
//  - in_valid outside IDLE ignored, no state change.
//  - kill: any non-IDLE state -> IDLE next edge, out_valid=0, result discarded; kill in IDLE no-op;
//    kill in DONE with out_ready=1: kill wins, no handshake counted.
//  - Adder operand mux is a pure function of state; adder idle (op1=op2=0) in IDLE/DONE.
//  - Adder has no carry-in: +1 always supplied on op2; cout bit used as 65th bit in MUL step.
// STRUCTURE
//  - Package mul_pkg: state enum (IDLE,ABS_A,ABS_B,MUL,NEG_LO,NEG_HI,DONE), op codes
//    OP_MUL/OP_MULH/OP_MULHSU/OP_MULHU, LATENCY=XLEN+4 constant.
//  - One sub-module: existing 64-bit cla adder, single instance u_cla; all else in this file.
// TESTING
//  1. MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> result 0xFFFF_FFFF_FFFF_FFFE; MUL same operands -> 0x1.
//  2. MULH a=b=0x8000_0000_0000_0000 -> 0x4000_0000_0000_0000; MULH a=-1,b=-1 -> 0x0.
//  3. MULHSU a=-1, b=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFF; MUL a=-3,b=5 -> -15 (0x...FFF1).
//  4. Latency/handshake: accept at edge 0 -> out_valid first high after edge 68; out_ready low 5
//     cycles -> out_valid/out_result stable, in_ready=0, in_valid pulses ignored.
//  5. kill at 10th MUL cycle -> IDLE next edge, in_ready=1, out_valid never asserts; next op correct.
//  6. rst asserted async during NEG_HI -> out_valid=0, out_result=0, in_ready=1 before next edge.

Source files
------------

// File: rtl/mul_pkg.sv
// mul_pkg: shared state encoding, op codes and timing constants for the sequential multiplier
package mul_pkg;

    localparam int MUL_XLEN = 64;
    localparam int LATENCY  = MUL_XLEN + 4;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ABS_A,
        ABS_B,
        MUL,
        NEG_LO,
        NEG_HI,
        DONE
    } state_e;

endpackage

// File: rtl/mul_seq_ctrl_cla.sv
// mul_seq_ctrl_cla: carry-lookahead adder built from 4-bit lookahead groups, no carry-in
module mul_seq_ctrl_cla #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] op1_i,
    input  logic [WIDTH-1:0] op2_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic             cin;

    assign p = op1_i ^ op2_i;
    assign g = op1_i & op2_i;

    // each group resolves its internal carries directly from the group carry-in
    always_comb begin
        sum_o = '0;
        cin   = 1'b0;
        for (int k = 0; k < WIDTH / 4; k++) begin
            sum_o[4*k]   = p[4*k] ^ cin;
            sum_o[4*k+1] = p[4*k+1] ^ (g[4*k] | (p[4*k] & cin));
            sum_o[4*k+2] = p[4*k+2] ^ (g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cin));
            sum_o[4*k+3] = p[4*k+3] ^ (g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                           | (p[4*k+2] & p[4*k+1] & p[4*k] & cin));
            cin = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]) | (&p[4*k +: 4] & cin);
        end
        cout_o = cin;
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: iterative shift-add multiplier (MUL/MULH/MULHSU/MULHU) sharing one CLA adder
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int XLEN = MUL_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [6:0]      cnt_q, cnt_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_b_q, neg_b_d;
    logic            neg_p_q, neg_p_d;
    logic            c_q, c_d;
    logic [XLEN-1:0] add_a;
    logic [XLEN-1:0] add_b;
    logic [XLEN-1:0] sum;
    logic            cout;
    logic [XLEN-1:0] hi_neg;

    assign in_ready   = state_q == IDLE;
    assign out_valid  = state_q == DONE;
    assign out_result = result_q;

    // adder operands depend only on state: +1 for negation rides on op2, shift-add uses hi+mcand
    assign add_a = state_q == ABS_A ? ~mcand_q :
                   (state_q == ABS_B || state_q == NEG_LO) ? ~lo_q :
                   state_q == MUL ? hi_q :
                   state_q == NEG_HI ? ~hi_q : '0;
    assign add_b = state_q == MUL ? mcand_q :
                   (state_q == ABS_A || state_q == ABS_B || state_q == NEG_LO) ? XLEN'(1) :
                   state_q == NEG_HI ? XLEN'(c_q) : '0;
    assign hi_neg = neg_p_q ? sum : hi_q;

    mul_seq_ctrl_cla #(.WIDTH(XLEN)) u_cla (
        .op1_i  (add_a),
        .op2_i  (add_b),
        .sum_o  (sum),
        .cout_o (cout)
    );

    // next-state and datapath sequencing; kill returns any busy state to IDLE
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        neg_p_d  = neg_p_q;
        c_d      = c_q;
        if (kill && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    state_d = ABS_A;
                    op_d    = in_op;
                    mcand_d = in_a;
                    lo_d    = in_b;
                    hi_d    = '0;
                    cnt_d   = '0;
                    c_d     = 1'b0;
                    neg_a_d = in_a[XLEN-1] & (in_op == OP_MULH || in_op == OP_MULHSU);
                    neg_b_d = in_b[XLEN-1] & (in_op == OP_MULH);
                    neg_p_d = neg_a_d ^ neg_b_d;
                end
                ABS_A: begin
                    state_d = ABS_B;
                    mcand_d = neg_a_q ? sum : mcand_q;
                end
                ABS_B: begin
                    state_d = MUL;
                    lo_d    = neg_b_q ? sum : lo_q;
                end
                MUL: begin
                    state_d = cnt_q == 7'(XLEN - 1) ? NEG_LO : MUL;
                    cnt_d   = cnt_q + 7'd1;
                    hi_d    = lo_q[0] ? {cout, sum[XLEN-1:1]} : {1'b0, hi_q[XLEN-1:1]};
                    lo_d    = {lo_q[0] ? sum[0] : hi_q[0], lo_q[XLEN-1:1]};
                end
                NEG_LO: begin
                    state_d = NEG_HI;
                    lo_d    = neg_p_q ? sum : lo_q;
                    c_d     = neg_p_q ? cout : c_q;
                end
                NEG_HI: begin
                    state_d  = DONE;
                    hi_d     = hi_neg;
                    result_d = op_q == OP_MUL ? lo_q : hi_neg;
                end
                DONE: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            neg_p_q  <= 1'b0;
            c_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            neg_p_q  <= neg_p_d;
            c_q      <= c_d;
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: scoreboard bench for the sequential multiplier with directed vectors
module tb_mul_seq_ctrl;
    import mul_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = '0;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    logic        kill = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_result;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    int          since = 1000;
    logic        prev_v = 1'b0;

    logic [1:0]  v_op[10] = '{OP_MULHU, OP_MUL, OP_MULH, OP_MULH, OP_MULHSU,
                              OP_MUL, OP_MULHU, OP_MULH, OP_MULHSU, OP_MUL};
    logic [63:0] v_a[10]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD,
                              64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE, 64'h2, 64'h1234};
    logic [63:0] v_b[10]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5,
                              64'h0000_0001_0000_0000, 64'h3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10};
    logic [63:0] v_e[10]  = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 64'h4000_0000_0000_0000,
                              64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1,
                              64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h12340};

    always #5 clk = ~clk;

    mul_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .kill       (kill),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         input bit push, input logic [63:0] e);
        int t = 0;
        while (!in_ready && t < 300) begin
            step(1);
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_timeout: in_ready stuck at 0 after %0d cycles", t);
        end else begin
            in_op    = op;
            in_a     = a;
            in_b     = b;
            in_valid = 1'b1;
            if (push) exp_q.push_back(e);
            step(1);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || !in_ready) && t < 400) begin
            step(1);
            t++;
        end
        if (exp_q.size() != 0 || !in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, in_ready=%b", exp_q.size(), in_ready);
            exp_q.delete();
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) since <= 1000;
        else if (in_valid && in_ready) since <= 0;
        else if (since < 1000) since <= since + 1;
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v) chk("latency", 64'(since), 64'(LATENCY));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got %h with no result outstanding", out_result);
                end else begin
                    chk("result", out_result, exp_q.pop_front());
                end
            end
            prev_v = out_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] held;
        logic        seen;
        int          t;
        rst = 1'b1;
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_result", out_result, 64'd0);
        step(2);
        rst = 1'b0;
        step(1);
        for (int i = 0; i < 10; i++) issue(v_op[i], v_a[i], v_b[i], 1'b1, v_e[i]);
        drain();
        out_ready = 1'b0;
        issue(OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 1'b1, 64'h1);
        t = 0;
        while (!out_valid && t < 200) begin
            step(1);
            t++;
        end
        chk("stall_valid_seen", 64'(out_valid), 64'd1);
        held = out_result;
        chk("stall_held_value", held, 64'h1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_op    = OP_MUL;
            in_a     = 64'(i + 9);
            in_b     = 64'd3;
            step(1);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_out_result", out_result, held);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step(1);
        chk("post_handshake_in_ready", 64'(in_ready), 64'd1);
        chk("post_handshake_out_valid", 64'(out_valid), 64'd0);
        drain();
        issue(OP_MUL, 64'd7, 64'd7, 1'b0, 64'd0);
        step(11);
        chk("kill_busy_before", 64'(in_ready), 64'd0);
        kill = 1'b1;
        step(1);
        kill = 1'b0;
        chk("kill_in_ready", 64'(in_ready), 64'd1);
        chk("kill_out_valid", 64'(out_valid), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            seen = seen | out_valid;
            step(1);
        end
        chk("kill_never_valid", 64'(seen), 64'd0);
        issue(OP_MULHU, 64'h8000_0000_0000_0000, 64'h4, 1'b1, 64'h2);
        drain();
        issue(OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0);
        step(67);
        chk("neg_hi_busy", 64'(in_ready), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_out_result", out_result, 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        step(2);
        rst = 1'b0;
        step(1);
        issue(OP_MULH, 64'hFFFF_FFFF_FFFF_FFFE, 64'h3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
